mem_stage: RTL and testbench

Memory-access stage of the RV32I pipeline, directly downstream of the execute stage. It registers the execute outputs, performs the load or store against a data memory with variable response latency, and presents a single registered writeback result. The byte/halfword lane steering, load sign/zero extension and misalignment detection all live here. It stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage. Registers execute results, runs the
// load/store handshake against a variable-latency data memory, steers byte
// lanes, extends load data, flags misaligned/illegal accesses, and emits one
// registered writeback pulse per instruction.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_funct3,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_link_sel,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd_addr,
    output logic        o_busy,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_valid,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd_addr,
    output logic        o_reg_write,
    output logic        o_fault
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;

    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic        ren_q, ren_d, wen_q, wen_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        regw_out_q, regw_out_d;
    logic        fault_q, fault_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;
    logic [4:0]  rd_q, rd_d;
    logic        regw_q, regw_d;

    logic        accept, is_mem, illegal, misal, fault, mem_done;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept   = (state_q == IDLE) && i_valid;
    assign is_mem   = i_mem_read || i_mem_write;
    assign mem_done = (state_q == ACCESS) && i_dmem_valid;
    assign illegal  = i_mem_read ? ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11))
                                 : (i_funct3 >= 3'b011);
    assign misal    = ((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
    assign fault    = illegal || misal;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: legal memory op enters ACCESS, completion returns to IDLE
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (accept && is_mem && !fault) state_d = ACCESS;
        end else begin
            if (i_dmem_valid) state_d = IDLE;
        end
    end

    // State-decoded output
    always_comb begin
        o_busy = (state_q == ACCESS);
    end

    // Store lane steering from the incoming address and size
    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = '0;
        if (i_mem_write) begin
            case (i_funct3[1:0])
                2'b00: begin
                    st_mask  = 4'b0001 << i_alu_result[1:0];
                    st_wdata = {4{i_rs2_data[7:0]}};
                end
                2'b01: begin
                    st_mask  = i_alu_result[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{i_rs2_data[15:0]}};
                end
                default: begin
                    st_mask  = 4'b1111;
                    st_wdata = i_rs2_data;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension from the latched access
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = i_dmem_rdata[7:0];
            2'd1:    ld_byte = i_dmem_rdata[15:8];
            2'd2:    ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    // Datapath next values: accept, request launch, completion, writeback pulse
    always_comb begin
        dmem_addr_d = dmem_addr_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        valid_d     = 1'b0;
        result_d    = result_q;
        rd_out_d    = rd_out_q;
        regw_out_d  = 1'b0;
        fault_d     = 1'b0;
        addr_d      = addr_q;
        f3_d        = f3_q;
        store_d     = store_q;
        rd_d        = rd_q;
        regw_d      = regw_q;
        if (accept) begin
            if (!is_mem) begin
                valid_d    = 1'b1;
                result_d   = i_link_sel ? (i_pc + 32'd4) : i_alu_result;
                rd_out_d   = i_rd_addr;
                regw_out_d = i_reg_write;
            end else if (fault) begin
                valid_d    = 1'b1;
                fault_d    = 1'b1;
                result_d   = i_alu_result;
                rd_out_d   = i_rd_addr;
            end else begin
                addr_d      = i_alu_result;
                f3_d        = i_funct3;
                store_d     = i_mem_write;
                rd_d        = i_rd_addr;
                regw_d      = i_reg_write;
                dmem_addr_d = {i_alu_result[31:2], 2'b00};
                ren_d       = i_mem_read;
                wen_d       = i_mem_write;
                mask_d      = st_mask;
                wdata_d     = st_wdata;
            end
        end
        if (mem_done) begin
            ren_d      = 1'b0;
            wen_d      = 1'b0;
            valid_d    = 1'b1;
            result_d   = store_q ? addr_q : ld_data;
            rd_out_d   = rd_q;
            regw_out_d = regw_q && !store_q;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dmem_addr_q <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            mask_q      <= '0;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_out_q    <= '0;
            regw_out_q  <= 1'b0;
            fault_q     <= 1'b0;
            addr_q      <= '0;
            f3_q        <= '0;
            store_q     <= 1'b0;
            rd_q        <= '0;
            regw_q      <= 1'b0;
        end else begin
            dmem_addr_q <= dmem_addr_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            rd_out_q    <= rd_out_d;
            regw_out_q  <= regw_out_d;
            fault_q     <= fault_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            store_q     <= store_d;
            rd_q        <= rd_d;
            regw_q      <= regw_d;
        end
    end

    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_ren   = ren_q;
    assign o_dmem_wen   = wen_q;
    assign o_dmem_mask  = mask_q;
    assign o_dmem_wdata = wdata_q;
    assign o_valid      = valid_q;
    assign o_result     = result_q;
    assign o_rd_addr    = rd_out_q;
    assign o_reg_write  = regw_out_q;
    assign o_fault      = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, self-checking bench for mem_stage.
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_rs2_data = '0;
    logic [31:0] i_pc = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic        i_link_sel = 1'b0;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_rd_addr = '0;
    logic        o_busy;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_ren;
    logic        o_dmem_wen;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic [31:0] i_dmem_rdata = '0;
    logic        i_dmem_valid = 1'b0;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;
    logic        o_reg_write;
    logic        o_fault;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_pc(i_pc),
        .i_funct3(i_funct3), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_link_sel(i_link_sel), .i_reg_write(i_reg_write), .i_rd_addr(i_rd_addr),
        .o_busy(o_busy), .o_dmem_addr(o_dmem_addr), .o_dmem_ren(o_dmem_ren),
        .o_dmem_wen(o_dmem_wen), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rdata(i_dmem_rdata), .i_dmem_valid(i_dmem_valid),
        .o_valid(o_valid), .o_result(o_result), .o_rd_addr(o_rd_addr),
        .o_reg_write(o_reg_write), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic mr, input logic mw,
                         input logic ln, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc);
        i_valid      = v;
        i_funct3     = f3;
        i_mem_read   = mr;
        i_mem_write  = mw;
        i_link_sel   = ln;
        i_reg_write  = rw;
        i_rd_addr    = rd;
        i_alu_result = alu;
        i_rs2_data   = rs2;
        i_pc         = pc;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        step();
        step();
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b exp=0", o_busy); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
        n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got=%0b exp=0", o_fault); end
        n_cmp++; if (o_reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_regw got=%0b exp=0", o_reg_write); end
        n_cmp++; if ({o_dmem_ren, o_dmem_wen} !== 2'b00) begin n_bad++; $display("FAIL rst_req got=%b exp=00", {o_dmem_ren, o_dmem_wen}); end
        n_cmp++; if (o_dmem_mask !== 4'h0) begin n_bad++; $display("FAIL rst_mask got=%b exp=0000", o_dmem_mask); end
        n_cmp++; if (o_dmem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%h exp=0", o_dmem_addr); end
        n_cmp++; if (o_dmem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got=%h exp=0", o_dmem_wdata); end
        n_cmp++; if (o_result !== 32'h0) begin n_bad++; $display("FAIL rst_result got=%h exp=0", o_result); end
        n_cmp++; if (o_rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_rd got=%0d exp=0", o_rd_addr); end
        i_rst = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h80);
        step();
        idle_inputs();
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid got=%0b exp=1", o_valid); end
        n_cmp++; if (o_result !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_result got=%h exp=00001234", o_result); end
        n_cmp++; if (o_rd_addr !== 5'd5) begin n_bad++; $display("FAIL alu_rd got=%0d exp=5", o_rd_addr); end
        n_cmp++; if (o_reg_write !== 1'b1) begin n_bad++; $display("FAIL alu_regw got=%0b exp=1", o_reg_write); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL alu_busy got=%0b exp=0", o_busy); end
        n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL alu_fault got=%0b exp=0", o_fault); end
        step();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL alu_pulse got=%0b exp=0", o_valid); end
        n_cmp++; if (o_reg_write !== 1'b0) begin n_bad++; $display("FAIL alu_regw_gate got=%0b exp=0", o_reg_write); end
    endtask

    task automatic test_jal();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'hDEAD_BEEF, 32'h0, 32'h0000_0100);
        step();
        idle_inputs();
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL jal_valid got=%0b exp=1", o_valid); end
        n_cmp++; if (o_result !== 32'h0000_0104) begin n_bad++; $display("FAIL jal_result got=%h exp=00000104", o_result); end
        step();
    endtask

    task automatic test_sb();
        int busy_cnt;
        busy_cnt = 0;
        drive(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0203, 32'hAABB_CCDD, 32'h0);
        step();
        idle_inputs();
        n_cmp++; if (o_dmem_wen !== 1'b1 || o_dmem_ren !== 1'b0) begin n_bad++; $display("FAIL sb_req got=ren%0b wen%0b exp=ren0 wen1", o_dmem_ren, o_dmem_wen); end
        n_cmp++; if (o_dmem_mask !== 4'b1000) begin n_bad++; $display("FAIL sb_mask got=%b exp=1000", o_dmem_mask); end
        n_cmp++; if (o_dmem_wdata !== 32'hDDDD_DDDD) begin n_bad++; $display("FAIL sb_wdata got=%h exp=dddddddd", o_dmem_wdata); end
        n_cmp++; if (o_dmem_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL sb_addr got=%h exp=00000200", o_dmem_addr); end
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) i_dmem_valid = 1'b1;
            if (o_busy === 1'b1) busy_cnt++;
            n_cmp++; if (o_dmem_wen !== 1'b1) begin n_bad++; $display("FAIL sb_hold_wen c=%0d got=%0b exp=1", c, o_dmem_wen); end
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL sb_early_valid c=%0d got=%0b exp=0", c, o_valid); end
            step();
        end
        i_dmem_valid = 1'b0;
        n_cmp++; if (busy_cnt != 3) begin n_bad++; $display("FAIL sb_busy_cycles got=%0d exp=3", busy_cnt); end
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL sb_valid got=%0b exp=1", o_valid); end
        n_cmp++; if (o_reg_write !== 1'b0) begin n_bad++; $display("FAIL sb_regw got=%0b exp=0", o_reg_write); end
        n_cmp++; if (o_busy !== 1'b0 || o_dmem_wen !== 1'b0) begin n_bad++; $display("FAIL sb_release got=busy%0b wen%0b exp=busy0 wen0", o_busy, o_dmem_wen); end
        step();
    endtask

    task automatic test_stores();
        logic [2:0]  f3 [2];
        logic [31:0] ad [2];
        logic [31:0] rs [2];
        logic [3:0]  em [2];
        logic [31:0] ew [2];
        f3[0] = 3'b001; ad[0] = 32'h0000_0206; rs[0] = 32'h1122_3344; em[0] = 4'b1100; ew[0] = 32'h3344_3344;
        f3[1] = 3'b010; ad[1] = 32'h0000_0208; rs[1] = 32'hCAFE_F00D; em[1] = 4'b1111; ew[1] = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, f3[i], 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, ad[i], rs[i], 32'h0);
            step();
            idle_inputs();
            n_cmp++; if (o_dmem_mask !== em[i]) begin n_bad++; $display("FAIL st%0d_mask got=%b exp=%b", i, o_dmem_mask, em[i]); end
            n_cmp++; if (o_dmem_wdata !== ew[i]) begin n_bad++; $display("FAIL st%0d_wdata got=%h exp=%h", i, o_dmem_wdata, ew[i]); end
            i_dmem_valid = 1'b1;
            step();
            i_dmem_valid = 1'b0;
            n_cmp++; if (o_valid !== 1'b1 || o_reg_write !== 1'b0) begin n_bad++; $display("FAIL st%0d_wb got=valid%0b regw%0b exp=valid1 regw0", i, o_valid, o_reg_write); end
        end
        step();
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [9];
        logic [31:0] ad [9];
        logic [31:0] rd [9];
        logic [31:0] ex [9];
        f3[0] = 3'b000; ad[0] = 32'h102; rd[0] = 32'h1280_3456; ex[0] = 32'hFFFF_FF80;
        f3[1] = 3'b100; ad[1] = 32'h102; rd[1] = 32'h1280_3456; ex[1] = 32'h0000_0080;
        f3[2] = 3'b000; ad[2] = 32'h101; rd[2] = 32'h1280_3456; ex[2] = 32'h0000_0034;
        f3[3] = 3'b001; ad[3] = 32'h102; rd[3] = 32'h1280_3456; ex[3] = 32'h0000_1280;
        f3[4] = 3'b101; ad[4] = 32'h100; rd[4] = 32'h1280_3456; ex[4] = 32'h0000_3456;
        f3[5] = 3'b001; ad[5] = 32'h102; rd[5] = 32'h8000_1234; ex[5] = 32'hFFFF_8000;
        f3[6] = 3'b101; ad[6] = 32'h102; rd[6] = 32'h8000_1234; ex[6] = 32'h0000_8000;
        f3[7] = 3'b010; ad[7] = 32'h104; rd[7] = 32'h1280_3456; ex[7] = 32'h1280_3456;
        f3[8] = 3'b000; ad[8] = 32'h103; rd[8] = 32'hF000_0000; ex[8] = 32'hFFFF_FFF0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, f3[i], 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, ad[i], 32'h0, 32'h0);
            step();
            idle_inputs();
            n_cmp++; if (o_dmem_ren !== 1'b1 || o_busy !== 1'b1) begin n_bad++; $display("FAIL ld%0d_req got=ren%0b busy%0b exp=ren1 busy1", i, o_dmem_ren, o_busy); end
            n_cmp++; if (o_dmem_addr !== {ad[i][31:2], 2'b00} || o_dmem_mask !== 4'b1111) begin n_bad++; $display("FAIL ld%0d_addr got=%h/%b exp=%h/1111", i, o_dmem_addr, o_dmem_mask, {ad[i][31:2], 2'b00}); end
            i_dmem_valid = 1'b1;
            i_dmem_rdata = rd[i];
            step();
            i_dmem_valid = 1'b0;
            i_dmem_rdata = 32'h5A5A_5A5A;
            n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL ld%0d_valid got=%0b exp=1", i, o_valid); end
            n_cmp++; if (o_result !== ex[i]) begin n_bad++; $display("FAIL ld%0d_result got=%h exp=%h", i, o_result, ex[i]); end
            n_cmp++; if (o_reg_write !== 1'b1 || o_rd_addr !== 5'd3) begin n_bad++; $display("FAIL ld%0d_wb got=regw%0b rd%0d exp=regw1 rd3", i, o_reg_write, o_rd_addr); end
        end
        step();
    endtask

    task automatic test_fault();
        logic [2:0]  f3 [8];
        logic [31:0] ad [8];
        logic        mw [8];
        f3[0] = 3'b010; ad[0] = 32'h1001; mw[0] = 1'b0;
        f3[1] = 3'b001; ad[1] = 32'h1003; mw[1] = 1'b0;
        f3[2] = 3'b010; ad[2] = 32'h1002; mw[2] = 1'b0;
        f3[3] = 3'b011; ad[3] = 32'h1000; mw[3] = 1'b0;
        f3[4] = 3'b110; ad[4] = 32'h1000; mw[4] = 1'b0;
        f3[5] = 3'b011; ad[5] = 32'h1000; mw[5] = 1'b1;
        f3[6] = 3'b001; ad[6] = 32'h0101; mw[6] = 1'b1;
        f3[7] = 3'b100; ad[7] = 32'h1000; mw[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, f3[i], !mw[i], mw[i], 1'b0, 1'b1, 5'd9, ad[i], 32'h1234_5678, 32'h0);
            step();
            idle_inputs();
            n_cmp++; if (o_valid !== 1'b1 || o_fault !== 1'b1) begin n_bad++; $display("FAIL flt%0d_flag got=valid%0b fault%0b exp=valid1 fault1", i, o_valid, o_fault); end
            n_cmp++; if (o_reg_write !== 1'b0) begin n_bad++; $display("FAIL flt%0d_regw got=%0b exp=0", i, o_reg_write); end
            n_cmp++; if (o_result !== ad[i]) begin n_bad++; $display("FAIL flt%0d_result got=%h exp=%h", i, o_result, ad[i]); end
            n_cmp++; if (o_dmem_ren !== 1'b0 || o_dmem_wen !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL flt%0d_noreq got=ren%0b wen%0b busy%0b exp=000", i, o_dmem_ren, o_dmem_wen, o_busy); end
        end
        step();
        n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL flt_pulse got=%0b exp=0", o_fault); end
    endtask

    task automatic test_back_to_back();
        i_dmem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h10 + 32'(i), 32'h0, 32'h0);
            step();
            n_cmp++; if (o_valid !== 1'b1 || o_result !== 32'h10 + 32'(i) || o_rd_addr !== 5'(i + 1)) begin n_bad++; $display("FAIL b2b%0d got=valid%0b res%h rd%0d exp=valid1 res%h rd%0d", i, o_valid, o_result, o_rd_addr, 32'h10 + 32'(i), i + 1); end
        end
        idle_inputs();
        i_dmem_valid = 1'b0;
        step();
        n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_end got=valid%0b busy%0b exp=00", o_valid, o_busy); end
    endtask

    task automatic test_hold_during_access();
        drive(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h300, 32'h0, 32'h0);
        step();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55, 32'h0, 32'h0);
        step();
        n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin n_bad++; $display("FAIL hold_ignore got=valid%0b busy%0b exp=valid0 busy1", o_valid, o_busy); end
        i_dmem_valid = 1'b1;
        i_dmem_rdata = 32'h0BAD_F00D;
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy_ack got=%0b exp=1", o_busy); end
        step();
        i_dmem_valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_result !== 32'h0BAD_F00D || o_rd_addr !== 5'd10) begin n_bad++; $display("FAIL hold_load got=valid%0b res%h rd%0d exp=valid1 res0badf00d rd10", o_valid, o_result, o_rd_addr); end
        step();
        idle_inputs();
        n_cmp++; if (o_valid !== 1'b1 || o_result !== 32'h55 || o_rd_addr !== 5'd9) begin n_bad++; $display("FAIL hold_next got=valid%0b res%h rd%0d exp=valid1 res55 rd9", o_valid, o_result, o_rd_addr); end
        step();
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h400, 32'h0, 32'h0);
        step();
        idle_inputs();
        n_cmp++; if (o_dmem_ren !== 1'b1) begin n_bad++; $display("FAIL rmid_req got=%0b exp=1", o_dmem_ren); end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        n_cmp++; if ({o_busy, o_dmem_ren, o_dmem_wen, o_valid, o_fault, o_reg_write} !== 6'b0) begin n_bad++; $display("FAIL rmid_ctrl got=%b exp=000000", {o_busy, o_dmem_ren, o_dmem_wen, o_valid, o_fault, o_reg_write}); end
        n_cmp++; if (o_dmem_addr !== 32'h0 || o_dmem_mask !== 4'h0 || o_result !== 32'h0 || o_rd_addr !== 5'd0) begin n_bad++; $display("FAIL rmid_data got=%h/%b/%h/%0d exp=0", o_dmem_addr, o_dmem_mask, o_result, o_rd_addr); end
        i_dmem_valid = 1'b1;
        i_dmem_rdata = 32'h1111_2222;
        step();
        i_dmem_valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_late got=valid%0b busy%0b exp=00", o_valid, o_busy); end
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h77, 32'h0, 32'h0);
        step();
        idle_inputs();
        n_cmp++; if (o_valid !== 1'b1 || o_result !== 32'h77 || o_rd_addr !== 5'd12) begin n_bad++; $display("FAIL rmid_next got=valid%0b res%h rd%0d exp=valid1 res77 rd12", o_valid, o_result, o_rd_addr); end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_jal();
        test_sb();
        test_stores();
        test_loads();
        test_fault();
        test_back_to_back();
        test_hold_during_access();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
